bin2bcd_8bit: RTL

- Sequential binary-to-BCD converter, directly downstream of the 4-bit multiplier.
- Takes the multiplier's 8-bit unsigned Product and produces three packed BCD digits for the seven-segment display path.
- Uses the shift-add-3 (double-dabble) algorithm, one shift per clock.
- Valid/ready handshakes on both the input and output sides.

---
 rtl/bin2bcd_8bit.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/bin2bcd_8bit.sv
// Sequential double-dabble binary-to-BCD converter with valid/ready handshakes on both sides.
// Optional leading-zero blank mask enabled by defining BIN2BCD_BLANK_EN.
module bin2bcd_8bit #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WIDTH-1:0]      bin,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic [DIGITS-1:0]     digit_blank
);

    localparam int SCR_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(WIDTH + 1);

    // True when DIGITS decimal digits can represent the largest WIDTH-bit value.
    function automatic bit digits_fit();
        longint unsigned p10;
        longint unsigned maxv;
        p10  = 1;
        maxv = (64'd1 << WIDTH) - 64'd1;
        for (int i = 0; i < DIGITS && p10 <= maxv; i++) begin
            p10 = p10 * 10;
        end
        return p10 > maxv;
    endfunction

    if (WIDTH < 1 || WIDTH > 62 || DIGITS < 1 || !digits_fit()) begin : g_param_check
        $fatal(1, "bin2bcd_8bit: DIGITS=%0d cannot hold 2^%0d-1", DIGITS, WIDTH);
    end

    function automatic logic [SCR_W-1:0] add3_digits(input logic [SCR_W-1:0] s);
        logic [SCR_W-1:0] r;
        logic [3:0]       nib;
        r = s;
        for (int i = 0; i < DIGITS; i++) begin
            nib = s[4*i +: 4];
            if (nib >= 4'd5) begin
                r[4*i +: 4] = nib + 4'd3;
            end
        end
        return r;
    endfunction

`ifdef BIN2BCD_BLANK_EN
    // Digit i blanks when it and every higher digit are zero; the ones digit always shows.
    function automatic logic [DIGITS-1:0] blank_mask(input logic [SCR_W-1:0] d);
        logic [DIGITS-1:0] m;
        logic              higher_zero;
        m           = '0;
        higher_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            higher_zero = higher_zero && (d[4*i +: 4] == 4'd0);
            m[i]        = higher_zero;
        end
        return m;
    endfunction
`endif

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [WIDTH-1:0]     shift_q;
    logic [SCR_W-1:0]     scratch_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [SCR_W-1:0]     bcd_q;
    logic [DIGITS-1:0]    blank_q;
    logic                 out_valid_q;

    logic [SCR_W-1:0]       scr_adj;
    logic [SCR_W+WIDTH-1:0] shifted;
    logic [SCR_W-1:0]       scr_next;
    logic [WIDTH-1:0]       shift_next;
    logic [DIGITS-1:0]      blank_next;
    logic                   last_shift;
    logic                   accept;

    assign in_ready    = rst_n && (state_q == IDLE);
    assign busy        = (state_q == CONV);
    assign out_valid   = out_valid_q;
    assign bcd         = bcd_q;
    assign digit_blank = blank_q;
    assign accept      = in_valid && in_ready;

    always_comb begin
        scr_adj    = add3_digits(scratch_q);
        shifted    = {scr_adj, shift_q} << 1;
        scr_next   = shifted[SCR_W+WIDTH-1:WIDTH];
        shift_next = shifted[WIDTH-1:0];
        last_shift = (cnt_q == CNT_W'(WIDTH - 1));
`ifdef BIN2BCD_BLANK_EN
        blank_next = blank_mask(scr_next);
`else
        blank_next = '0;
`endif
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)     state_d = CONV;
            CONV:    if (last_shift) state_d = DONE;
            DONE:    if (out_ready)  state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath: load on accept, one add-3/shift per CONV edge, hold result through DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q     <= '0;
            scratch_q   <= '0;
            cnt_q       <= '0;
            bcd_q       <= '0;
            blank_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        shift_q   <= bin;
                        scratch_q <= '0;
                        cnt_q     <= '0;
                    end
                end
                CONV: begin
                    scratch_q <= scr_next;
                    shift_q   <= shift_next;
                    cnt_q     <= cnt_q + CNT_W'(1);
                    if (last_shift) begin
                        bcd_q       <= scr_next;
                        blank_q     <= blank_next;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
